// File: rtl/sdram_port_arbiter_pkg.sv
// sdram_arb_pkg: shared types and defaults for the SDRAM port arbiter.
//   arb_state_e  - arbiter FSM states
//   DEF_*        - default port count, address/data widths and watchdog limit
//   timer_width  - width of the watchdog timer for a given TIMEOUT
package sdram_arb_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_INIT = 3'd0,
        ST_IDLE      = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT      = 3'd3,
        ST_DONE      = 3'd4
    } arb_state_e;

    localparam int DEF_NPORTS  = 4;
    localparam int DEF_ADDR_W  = 22;
    localparam int DEF_DATA_W  = 128;
    localparam int DEF_TIMEOUT = 1024;

    // The timer never needs to hold more than TIMEOUT-1.
    function automatic int timer_width(input int timeout);
        return $clog2(timeout);
    endfunction

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// sdram_port_arbiter_if: bundles the client-side request ports and the
// controller-side request/ack signals of the arbiter.
//   slave  modport - the arbiter's view (drives o* signals)
//   master modport - the environment's view (clients + controller, drives i*)
interface sdram_port_arbiter_if
    import sdram_arb_pkg::*;
#(
    parameter int NPORTS = DEF_NPORTS,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    // client side
    logic [NPORTS-1:0]        ireq;
    logic [NPORTS-1:0]        iwe;
    logic [NPORTS*ADDR_W-1:0] iaddr;
    logic [NPORTS*DATA_W-1:0] iwdata;
    logic [NPORTS-1:0]        oack;
    logic [NPORTS-1:0]        oerr;
    logic [DATA_W-1:0]        ordata;
    logic [NPORTS-1:0]        ogrant;
    logic                     obusy;
    // controller side
    logic                     iinit_done;
    logic                     owrite_req;
    logic                     oread_req;
    logic [ADDR_W-1:0]        owrite_address;
    logic [ADDR_W-1:0]        oread_address;
    logic [DATA_W-1:0]        owrite_data;
    logic                     iwrite_ack;
    logic                     iread_ack;
    logic [DATA_W-1:0]        iread_data;

    modport slave (
        input  ireq, iwe, iaddr, iwdata, iinit_done, iwrite_ack, iread_ack, iread_data,
        output oack, oerr, ordata, ogrant, obusy,
        output owrite_req, oread_req, owrite_address, oread_address, owrite_data
    );

    modport master (
        output ireq, iwe, iaddr, iwdata, iinit_done, iwrite_ack, iread_ack, iread_data,
        input  oack, oerr, ordata, ogrant, obusy,
        input  owrite_req, oread_req, owrite_address, oread_address, owrite_data
    );

endinterface

// File: rtl/sdram_port_arbiter_rr_pick.sv
// sdram_rr_pick: combinational rotating-priority picker.
//   req_i   - request vector
//   ptr_i   - port with highest priority this round
//   grant_o - one-hot winner (0 when nothing requests)
//   idx_o   - index of the winner
//   any_o   - at least one request present
module sdram_rr_pick
    import sdram_arb_pkg::*;
#(
    parameter int NPORTS = DEF_NPORTS,
    parameter int IDX_W  = $clog2(DEF_NPORTS)
) (
    input  logic [NPORTS-1:0] req_i,
    input  logic [IDX_W-1:0]  ptr_i,
    output logic [NPORTS-1:0] grant_o,
    output logic [IDX_W-1:0]  idx_o,
    output logic              any_o
);

    logic [NPORTS-1:0] one_s;
    logic [IDX_W-1:0]  pos_s;
    logic              hit_s;

    assign one_s = {{(NPORTS-1){1'b0}}, 1'b1};

    // Walk from ptr upward with wrap; the first requester found wins.
    always_comb begin
        grant_o = {NPORTS{1'b0}};
        idx_o   = {IDX_W{1'b0}};
        any_o   = 1'b0;
        pos_s   = {IDX_W{1'b0}};
        hit_s   = 1'b0;
        for (int i = 0; i < NPORTS; i++) begin
            pos_s   = IDX_W'((int'(ptr_i) + i) % NPORTS);
            hit_s   = !any_o && req_i[pos_s];
            grant_o = hit_s ? (one_s << pos_s) : grant_o;
            idx_o   = hit_s ? pos_s : idx_o;
            any_o   = any_o || hit_s;
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares one SDRAM controller among NPORTS requesters.
// A round-robin pick in IDLE latches the winner's op/address/data, ISSUE
// sends a one-cycle request pulse to the controller, WAIT looks for the
// matching ack (or times out), DONE returns oack/oerr to the winner.
//   iclk, ireset - clock, asynchronous active-high reset
//   bus (slave)  - client req/ack ports and controller request/ack ports
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NPORTS  = DEF_NPORTS,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                 iclk,
    input  logic                 ireset,
    sdram_port_arbiter_if.slave  bus
);

    localparam int IDX_W = $clog2(NPORTS);
    localparam int TW    = timer_width(TIMEOUT);

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              we_q, we_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [NPORTS-1:0] grant_q, grant_d;
    logic              busy_q, busy_d;
    logic              wreq_q, wreq_d;
    logic              rreq_q, rreq_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [NPORTS-1:0] ack_q, ack_d;
    logic [NPORTS-1:0] err_q, err_d;

    logic [NPORTS-1:0] pick_grant_s;
    logic [IDX_W-1:0]  pick_idx_s;
    logic              pick_any_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic              op_ack_s;

    sdram_rr_pick #(
        .NPORTS (NPORTS),
        .IDX_W  (IDX_W)
    ) u_pick (
        .req_i   (bus.ireq),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant_s),
        .idx_o   (pick_idx_s),
        .any_o   (pick_any_s)
    );

    // Select the candidate winner's address and write data.
    always_comb begin
        sel_addr_s  = {ADDR_W{1'b0}};
        sel_wdata_s = {DATA_W{1'b0}};
        for (int p = 0; p < NPORTS; p++) begin
            sel_addr_s  = (pick_idx_s == IDX_W'(p)) ? bus.iaddr[p*ADDR_W +: ADDR_W]  : sel_addr_s;
            sel_wdata_s = (pick_idx_s == IDX_W'(p)) ? bus.iwdata[p*DATA_W +: DATA_W] : sel_wdata_s;
        end
    end

    // Next-state and next-output logic of the arbitration FSM.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        we_d    = we_q;
        timer_d = timer_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        busy_d  = busy_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        wreq_d  = 1'b0;
        rreq_d  = 1'b0;
        ack_d   = {NPORTS{1'b0}};
        err_d   = {NPORTS{1'b0}};
        // only the ack of the latched op type counts
        op_ack_s = we_q ? bus.iwrite_ack : bus.iread_ack;
        case (state_q)
            ST_WAIT_INIT: begin
                grant_d = {NPORTS{1'b0}};
                busy_d  = 1'b0;
                if (bus.iinit_done) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_INIT;
                end
            end
            ST_IDLE: begin
                if (!bus.iinit_done) begin
                    state_d = ST_WAIT_INIT;
                end else if (pick_any_s) begin
                    state_d = ST_ISSUE;
                    idx_d   = pick_idx_s;
                    we_d    = bus.iwe[pick_idx_s];
                    addr_d  = sel_addr_s;
                    wdata_d = sel_wdata_s;
                    grant_d = pick_grant_s;
                    busy_d  = 1'b1;
                    // the request pulse is registered, so it shows in ISSUE
                    wreq_d  = bus.iwe[pick_idx_s];
                    rreq_d  = !bus.iwe[pick_idx_s];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                timer_d = {TW{1'b0}};
                if (!bus.iinit_done) begin
                    state_d = ST_DONE;
                    err_d   = grant_q;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!bus.iinit_done) begin
                    state_d = ST_DONE;
                    err_d   = grant_q;
                end else if (op_ack_s) begin
                    state_d = ST_DONE;
                    ack_d   = grant_q;
                    rdata_d = we_q ? rdata_q : bus.iread_data;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    state_d = ST_DONE;
                    err_d   = grant_q;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_DONE: begin
                grant_d = {NPORTS{1'b0}};
                busy_d  = 1'b0;
                ptr_d   = (idx_q == IDX_W'(NPORTS - 1)) ? {IDX_W{1'b0}} : idx_q + IDX_W'(1);
                if (bus.iinit_done) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_INIT;
                end
            end
            default: begin
                state_d = ST_WAIT_INIT;
                grant_d = {NPORTS{1'b0}};
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, latches and registered outputs.
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            state_q <= ST_WAIT_INIT;
            idx_q   <= {IDX_W{1'b0}};
            we_q    <= 1'b0;
            timer_q <= {TW{1'b0}};
            ptr_q   <= {IDX_W{1'b0}};
            grant_q <= {NPORTS{1'b0}};
            busy_q  <= 1'b0;
            wreq_q  <= 1'b0;
            rreq_q  <= 1'b0;
            addr_q  <= {ADDR_W{1'b0}};
            wdata_q <= {DATA_W{1'b0}};
            rdata_q <= {DATA_W{1'b0}};
            ack_q   <= {NPORTS{1'b0}};
            err_q   <= {NPORTS{1'b0}};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            timer_q <= timer_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            wreq_q  <= wreq_d;
            rreq_q  <= rreq_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign bus.oack           = ack_q;
    assign bus.oerr           = err_q;
    assign bus.ordata         = rdata_q;
    assign bus.ogrant         = grant_q;
    assign bus.obusy          = busy_q;
    assign bus.owrite_req     = wreq_q;
    assign bus.oread_req      = rreq_q;
    assign bus.owrite_address = addr_q;
    assign bus.oread_address  = addr_q;
    assign bus.owrite_data    = wdata_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: directed client/controller stimulus, a
// transaction-level model checked every cycle on the falling edge, and
// literal latency/value expectations for the key scenarios.
module tb_sdram_port_arbiter;

    localparam int NP = 4;
    localparam int AW = 22;
    localparam int DW = 128;
    localparam int TO = 16;
    localparam logic [DW-1:0] FACE = {8{16'hFACE}};
    localparam logic [DW-1:0] IDLE_RD = {4{32'h0BAD_F00D}};

    logic clk = 1'b0;
    logic ireset;
    always #5 clk = ~clk;

    sdram_port_arbiter_if #(.NPORTS(NP), .ADDR_W(AW), .DATA_W(DW)) bus ();

    sdram_port_arbiter #(.NPORTS(NP), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .iclk   (clk),
        .ireset (ireset),
        .bus    (bus)
    );

    int nchecks = 0;
    int nerrs   = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NP-1:0] oh(input int p);
        return NP'(1) << p;
    endfunction

    // ---------------- transaction-level model / compare process ----------
    logic [NP-1:0]    prev_req, prev_we;
    logic [NP*AW-1:0] prev_addr;
    logic [NP*DW-1:0] prev_wdata;
    bit               pend, res, ok, pwe, found;
    int               pport, issue_t, done_t, t, mptr, wp;
    logic [DW-1:0]    exp_rd, model_rd, model_wdata;
    logic [AW-1:0]    model_addr;
    int               ack_cnt [NP];
    int               grant_log [$];

    // Falling-edge compare of DUT outputs against the transaction model.
    always @(negedge clk) begin
        t++;
        if (ireset) begin
            pend = 1'b0; mptr = 0;
            model_rd = '0; model_addr = '0; model_wdata = '0;
            chk("reset_ctrl", {bus.oack, bus.oerr, bus.ogrant, bus.obusy, bus.owrite_req, bus.oread_req}, '0);
            chk("reset_bus", {bus.owrite_address, bus.oread_address}, '0);
            chk("reset_data", bus.owrite_data | bus.ordata, '0);
        end else begin
            chk("grant_onehot", $onehot0(bus.ogrant), 1'b1);
            if (pend && !res && t > issue_t) begin
                if ((pwe && bus.iwrite_ack) || (!pwe && bus.iread_ack)) begin
                    res = 1'b1; ok = 1'b1; done_t = t + 1; exp_rd = bus.iread_data;
                end else if (t - issue_t == TO) begin
                    res = 1'b1; ok = 1'b0; done_t = t + 1;
                end
            end
            chk("oack", bus.oack, (pend && res && ok && t == done_t) ? oh(pport) : '0);
            chk("oerr", bus.oerr, (pend && res && !ok && t == done_t) ? oh(pport) : '0);
            if (bus.owrite_req || bus.oread_req) begin
                chk("pulse_only_when_free", pend, 1'b0);
                found = 1'b0; wp = 0;
                for (int i = 0; i < NP; i++) begin
                    if (!found && prev_req[(mptr + i) % NP]) begin
                        found = 1'b1; wp = (mptr + i) % NP;
                    end
                end
                chk("pulse_has_requester", found, 1'b1);
                chk("pulse_write", bus.owrite_req, prev_we[wp]);
                chk("pulse_read", bus.oread_req, !prev_we[wp]);
                if (prev_we[wp]) chk("pulse_wdata", bus.owrite_data, prev_wdata[wp*DW +: DW]);
                grant_log.push_back(wp);
                pend = 1'b1; res = 1'b0; pport = wp; pwe = prev_we[wp]; issue_t = t;
                model_addr = prev_addr[wp*AW +: AW];
                model_wdata = prev_wdata[wp*DW +: DW];
            end
            chk("ogrant", bus.ogrant, pend ? oh(pport) : '0);
            chk("obusy", bus.obusy, pend);
            if (pend && res && t == done_t) begin
                if (ok && !pwe) model_rd = exp_rd;
                if (ok) ack_cnt[pport]++;
                pend = 1'b0;
                mptr = (pport + 1) % NP;
            end
            chk("ordata_hold", bus.ordata, model_rd);
            chk("waddr_hold", bus.owrite_address, model_addr);
            chk("raddr_hold", bus.oread_address, model_addr);
            chk("wdata_hold", bus.owrite_data, model_wdata);
        end
        prev_req = bus.ireq; prev_we = bus.iwe; prev_addr = bus.iaddr; prev_wdata = bus.iwdata;
    end

    // ---------------- clients + controller stub --------------------------
    bit            st_active, ack_en, wrong_en, st_we;
    int            st_cnt, ack_delay, wrong_delay;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] mem [logic [AW-1:0]];

    task automatic tick();
        @(posedge clk);
        #1;
        bus.iwrite_ack = 1'b0;
        bus.iread_ack  = 1'b0;
        bus.iread_data = IDLE_RD;
        if (ireset) begin
            bus.ireq = '0;
            st_active = 1'b0;
        end else begin
            bus.ireq = bus.ireq & ~(bus.oack | bus.oerr);
            if (bus.owrite_req || bus.oread_req) begin
                st_active = 1'b1; st_cnt = 0; st_we = bus.owrite_req; st_addr = bus.owrite_address;
                if (bus.owrite_req) mem[bus.owrite_address] = bus.owrite_data;
            end else if (st_active) begin
                st_cnt++;
                if (wrong_en && st_cnt == wrong_delay) begin
                    if (st_we) bus.iread_ack = 1'b1;
                    else       bus.iwrite_ack = 1'b1;
                end
                if (ack_en && st_cnt == ack_delay) begin
                    if (st_we) begin
                        bus.iwrite_ack = 1'b1;
                    end else begin
                        bus.iread_ack  = 1'b1;
                        bus.iread_data = mem.exists(st_addr) ? mem[st_addr] : {4{10'h0, st_addr}};
                    end
                    st_active = 1'b0;
                end
            end
        end
    endtask

    task automatic set_port(input int p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.iwe[p] = we;
        bus.iaddr[p*AW +: AW] = a;
        bus.iwdata[p*DW +: DW] = d;
        bus.ireq[p] = 1'b1;
    endtask

    task automatic wait_pulse(input int max, output int n);
        n = -1;
        for (int k = 1; k <= max && n < 0; k++) begin
            tick();
            if (bus.owrite_req || bus.oread_req) n = k;
        end
        if (n < 0) begin
            nchecks++; nerrs++;
            $display("FAIL wait_pulse: no controller pulse within %0d cycles", max);
        end
    endtask

    task automatic wait_done(input int max, output int n);
        n = -1;
        for (int k = 1; k <= max && n < 0; k++) begin
            tick();
            if ((bus.oack | bus.oerr) != '0) n = k;
        end
        if (n < 0) begin
            nchecks++; nerrs++;
            $display("FAIL wait_done: no oack/oerr within %0d cycles", max);
        end
    endtask

    task automatic do_reset();
        ireset = 1'b1;
        bus.iinit_done = 1'b0;
        tick(); tick();
        ireset = 1'b0;
        tick();
        bus.iinit_done = 1'b1;
        tick(); tick();
    endtask

    int n, tot;

    initial begin
        ireset = 1'b1;
        bus.ireq = '0; bus.iwe = '0; bus.iaddr = '0; bus.iwdata = '0;
        bus.iinit_done = 1'b0; bus.iwrite_ack = 1'b0; bus.iread_ack = 1'b0; bus.iread_data = IDLE_RD;
        ack_en = 1'b1; ack_delay = 2; wrong_en = 1'b0; wrong_delay = 0;
        for (int i = 0; i < NP; i++) ack_cnt[i] = 0;
        repeat (3) tick();
        chk("rst_ogrant", bus.ogrant, 4'b0000);
        chk("rst_obusy", bus.obusy, 1'b0);
        chk("rst_pulses", {bus.owrite_req, bus.oread_req}, 2'b00);
        chk("rst_ordata", bus.ordata, 128'h0);
        ireset = 1'b0;
        tick(); tick();

        // request before init: held off until init, pulse 2 cycles after rise
        set_port(1, 1'b0, 22'h000123, 128'h1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("no_pulse_before_init", {bus.owrite_req, bus.oread_req}, 2'b00);
        end
        bus.iinit_done = 1'b1;
        wait_pulse(10, n);
        chk("init_to_pulse", n, 2);
        chk("init_grant", bus.ogrant, 4'b0010);
        wait_done(40, n);
        chk("read_latency", n, 3);

        // write then read on port 2, ack after 5 cycles
        ack_delay = 5;
        set_port(2, 1'b1, 22'h000004, FACE);
        wait_pulse(10, n);
        chk("done_to_pulse", n, 2);
        chk("wr_pulse", bus.owrite_req, 1'b1);
        chk("wr_addr", bus.owrite_address, 22'h000004);
        chk("wr_data", bus.owrite_data, FACE);
        wait_done(40, n);
        chk("write_ack_latency", n, 6);
        chk("write_oack", bus.oack, 4'b0100);
        set_port(2, 1'b0, 22'h000004, 128'h0);
        wait_pulse(10, n);
        chk("rd_pulse", bus.oread_req, 1'b1);
        wait_done(40, n);
        chk("read_oack", bus.oack, 4'b0100);
        chk("read_data", bus.ordata, FACE);

        // all four ports at once after reset: order 0,1,2,3
        do_reset();
        ack_delay = 2;
        grant_log.delete();
        for (int i = 0; i < NP; i++) ack_cnt[i] = 0;
        for (int i = 0; i < NP; i++) set_port(i, 1'b1, AW'(32'h100 + i), DW'(i + 7));
        tot = 0;
        for (int k = 0; k < 200 && tot < NP; k++) begin
            tick();
            tot = ack_cnt[0] + ack_cnt[1] + ack_cnt[2] + ack_cnt[3];
        end
        repeat (4) tick();
        chk("rr_count", grant_log.size(), 4);
        for (int i = 0; i < NP; i++) begin
            chk("rr_order", (grant_log.size() > i) ? grant_log[i] : -1, i);
            chk("rr_one_ack", ack_cnt[i], 1);
        end

        // timeout on port 3, then a normal read on port 0
        ack_en = 1'b0;
        set_port(3, 1'b1, 22'h000200, 128'h55);
        wait_pulse(10, n);
        wait_done(40, n);
        chk("timeout_latency", n, 17);
        chk("timeout_oerr", bus.oerr, 4'b1000);
        chk("timeout_no_oack", bus.oack, 4'b0000);
        ack_en = 1'b1;
        set_port(0, 1'b0, 22'h000004, 128'h0);
        wait_pulse(10, n);
        wait_done(40, n);
        chk("after_timeout_latency", n, 3);
        chk("after_timeout_oack", bus.oack, 4'b0001);
        chk("after_timeout_data", bus.ordata, FACE);

        // wrong-type ack ignored; correct ack 3 cycles later completes
        wrong_en = 1'b1; wrong_delay = 2; ack_delay = 5;
        set_port(1, 1'b1, 22'h000010, 128'hABCD);
        wait_pulse(10, n);
        wait_done(40, n);
        chk("wrong_type_latency", n, 6);
        chk("wrong_type_oack", bus.oack, 4'b0010);
        wrong_en = 1'b0;

        // ack in the very last WAIT cycle still succeeds
        ack_delay = TO;
        set_port(2, 1'b0, 22'h000010, 128'h0);
        wait_pulse(10, n);
        wait_done(40, n);
        chk("late_ack_latency", n, 17);
        chk("late_ack_oack", bus.oack, 4'b0100);
        chk("late_ack_data", bus.ordata, 128'hABCD);

        // reset in the middle of WAIT
        ack_en = 1'b0; ack_delay = 2;
        set_port(2, 1'b1, 22'h000300, 128'h99);
        wait_pulse(10, n);
        tick(); tick(); tick();
        chk("pre_reset_busy", bus.obusy, 1'b1);
        #2;
        ireset = 1'b1;
        bus.iinit_done = 1'b0;
        #1;
        chk("mid_reset_grant", bus.ogrant, 4'b0000);
        chk("mid_reset_busy", bus.obusy, 1'b0);
        chk("mid_reset_ackerr", {bus.oack, bus.oerr}, 8'h00);
        chk("mid_reset_addr", bus.owrite_address, 22'h0);
        tick(); tick();
        ireset = 1'b0;
        ack_en = 1'b1;
        set_port(3, 1'b1, 22'h000400, 128'h3);
        set_port(0, 1'b1, 22'h000500, 128'h4);
        tick();
        bus.iinit_done = 1'b1;
        wait_pulse(10, n);
        chk("post_reset_first", bus.ogrant, 4'b0001);
        wait_done(40, n);
        wait_pulse(10, n);
        chk("post_reset_second", bus.ogrant, 4'b1000);
        wait_done(40, n);
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
